watch_calendar_gen2: RTL and testbench
======================================

// Module: watch_calendar_gen2
// PURPOSE
//  Parametrised calendar/time-of-day keeper for the watch datapath. Advances Y/M/D h:m:s on each
//  clk1sec enable, keeps an incremental day-of-week, validates loads, and emits carry pulses plus a
//  daily hh:mm alarm hit for display/alarm blocks. Adds load checking, 12h view and configurable year range.
// PARAMETERS
//  YEAR_W    12    year field width (bits)
//  YEAR_MIN  1     first legal year; wrap target after YEAR_MAX
//  YEAR_MAX  4095  last legal year; must be < 2**YEAR_W
//  RST_YEAR  2021  reset year (reset date = 12/31 23:59:50)
//  RST_WEEK  5     reset weekday, 0=Sun..6=Sat; must match reset date
// PORTS
//  clk        in   1          system clock, all state on posedge
//  rst        in   1          asynchronous, active-low reset
//  clk1sec    in   1          one-cycle tick enable, 1 Hz
//  set_time   in   1          load request, one-cycle pulse
//  bin_time   in   YEAR_W+26  {year,month[3:0],day[4:0],hour[4:0],min[5:0],sec[5:0]}
//  alarm_en   in   1          enable alarm compare
//  alarm_hour in   5          alarm hour 0..23
//  alarm_min  in   6          alarm minute 0..59
//  year       out  YEAR_W     current year
//  month      out  4          1..12
//  day        out  5          1..max_date
//  hour       out  5          0..23
//  minute     out  6          0..59
//  second     out  6          0..59
//  week       out  3          0=Sun..6=Sat
//  max_date   out  5          days in current month (comb.)
//  leap       out  1          current year is Gregorian leap (comb.)
//  hour12     out  4          1..12 view of hour (comb.)
//  pm         out  1          hour>=12 (comb.)
//  min_carry  out  1          pulse: second wrapped 59->0
//  hour_carry out  1          pulse: minute wrapped 59->0
//  day_carry  out  1          pulse: day advanced (hour 23->0)
//  set_ok     out  1          pulse: load accepted
//  set_err    out  1          pulse: load rejected
//  alarm_hit  out  1          pulse: new time == alarm_hour:alarm_min:00
// BEHAVIOUR
//  - Reset: RST_YEAR-12-31 23:59:50, week=RST_WEEK, every pulse output 0.
//  - All pulses are registered, high exactly one cycle, coincident with the updated time registers.
//  - Priority per cycle: set_time > clk1sec. A tick in the same cycle as set_time is dropped.
//  - Tick carry chain: sec 59->0 (min_carry); min 59->0 (hour_carry); hour 23->0 (day_carry,
//    week=(week+1)%7); day==max_date -> 1, month+1; month 12 -> 1, year+1; year YEAR_MAX -> YEAR_MIN.
//  - Week increments on every day rollover, including year wrap; no gap at YEAR_MAX->YEAR_MIN.
//  - leap: (y%4==0 && y%100!=0) || y%400==0. max_date uses leap for Feb (28/29); 31/30 otherwise.
//  - Load: valid iff YEAR_MIN<=year<=YEAR_MAX, 1<=month<=12, 1<=day<=max_date(month,year of
//    bin_time), hour<24, min<60, sec<60. Valid -> all fields loaded next edge, week = Zeller
//    day-of-week of loaded date, set_ok=1. Invalid -> state unchanged, set_err=1.
//  - hour12: hour 0 -> 12, 13..23 -> hour-12, else hour. pm=(hour>=12).
//  - alarm_hit: only on a tick-driven update (never on load) with alarm_en=1 and the new
//    time == alarm_hour:alarm_min:00. Out-of-range alarm values never match.
//  - Reset mid-operation wins immediately; a pending load or tick is discarded.
// STRUCTURE
//  - watch_pkg: field widths (MON_W=4, DAY_W=5, HR_W=5, MIN_W=6, SEC_W=6), weekday constants
//    SUN..SAT, functions is_leap(year) and days_in_month(month,leap).
//  - One sub-module watch_dow: combinational Gregorian Zeller (year,month,day)->week, used
//    only on load. Carry chain, validation, alarm compare stay in this module.
// TESTING
//  - Reset -> 2021-12-31 23:59:50, week=5; 10 ticks -> 2022-01-01 00:00:00, week=6,
//    min/hour/day_carry all high on 10th-tick update.
//  - Load 2024-02-28 23:59:59, tick -> 2024-02-29, week=4; load 2023-02-28 23:59:59,
//    tick -> 2023-03-01, week=3.
//  - Load 2023-02-29 / 2100-02-29 / month 13 / hour 24 -> set_err=1, time unchanged;
//    2000-02-29 -> set_ok=1, week=2.
//  - Load YEAR_MAX-12-31 23:59:59, tick -> YEAR_MIN-01-01 00:00:00, week advanced by one.
//  - alarm_en=1, 07:30: run 07:29:59 -> tick -> alarm_hit one cycle; load 07:30:00 -> no hit;
//    set_time with clk1sec same cycle -> loaded value, no increment.
//  - Assert rst mid-run between ticks -> reset values in the same cycle, pulses 0; hour 0/12/13
//    -> hour12 12/12/1, pm 0/1/1.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared field widths, weekday encoding and calendar helpers for the watch datapath.
package watch_pkg;

  localparam int unsigned MON_W = 4;
  localparam int unsigned DAY_W = 5;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;

  typedef enum logic [2:0] {
    SUN = 3'd0,
    MON = 3'd1,
    TUE = 3'd2,
    WED = 3'd3,
    THU = 3'd4,
    FRI = 3'd5,
    SAT = 3'd6
  } weekday_t;

  function automatic logic is_leap(input logic [31:0] y);
    return ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
  endfunction

  // Out-of-range months report 0 days so any day value fails validation.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m, input logic leap);
    case (m)
      4'd2:                                    return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:                 return 5'd30;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return 5'd31;
      default:                                 return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/watch_dow.sv
// Combinational Gregorian Zeller congruence: (year, month, day) -> weekday 0=Sun..6=Sat.
module watch_dow
  import watch_pkg::*;
#(
  parameter int unsigned YEAR_W = 12
) (
  input  logic [YEAR_W-1:0] year,
  input  logic [MON_W-1:0]  month,
  input  logic [DAY_W-1:0]  day,
  output logic [2:0]        week
);

  logic [31:0] y, m, q, k, j, h;

  // Jan/Feb count as months 13/14 of the previous year; h is 0=Sat, rotated to 0=Sun.
  always_comb begin
    y = 32'(year);
    m = 32'(month);
    q = 32'(day);
    if (m < 32'd3) begin
      m = m + 32'd12;
      y = y - 32'd1;
    end
    k = y % 32'd100;
    j = y / 32'd100;
    h = (q + (32'd13 * (m + 32'd1)) / 32'd5 + k + k / 32'd4 + j / 32'd4 + 32'd5 * j) % 32'd7;
    week = 3'((h + 32'd6) % 32'd7);
  end

endmodule

// File: rtl/watch_calendar_gen2.sv
// Calendar/time-of-day keeper: 1 Hz carry chain, validated loads, weekday tracking, 12h view, alarm.
module watch_calendar_gen2
  import watch_pkg::*;
#(
  parameter int unsigned YEAR_W   = 12,
  parameter int unsigned YEAR_MIN = 1,
  parameter int unsigned YEAR_MAX = 4095,
  parameter int unsigned RST_YEAR = 2021,
  parameter int unsigned RST_WEEK = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk1sec,
  input  logic              set_time,
  input  logic [YEAR_W+25:0] bin_time,
  input  logic              alarm_en,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_min,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        month,
  output logic [4:0]        day,
  output logic [4:0]        hour,
  output logic [5:0]        minute,
  output logic [5:0]        second,
  output logic [2:0]        week,
  output logic [4:0]        max_date,
  output logic              leap,
  output logic [3:0]        hour12,
  output logic              pm,
  output logic              min_carry,
  output logic              hour_carry,
  output logic              day_carry,
  output logic              set_ok,
  output logic              set_err,
  output logic              alarm_hit
);

  logic [YEAR_W-1:0] ld_year;
  logic [MON_W-1:0]  ld_mon;
  logic [DAY_W-1:0]  ld_day, ld_max;
  logic [HR_W-1:0]   ld_hour;
  logic [MIN_W-1:0]  ld_min;
  logic [SEC_W-1:0]  ld_sec;
  logic              ld_valid;
  logic [2:0]        ld_week;

  logic [YEAR_W-1:0] n_year;
  logic [MON_W-1:0]  n_mon;
  logic [DAY_W-1:0]  n_day;
  logic [HR_W-1:0]   n_hour;
  logic [MIN_W-1:0]  n_min;
  logic [SEC_W-1:0]  n_sec;
  logic [2:0]        n_week;
  logic              n_mc, n_hc, n_dc, n_alarm;

  assign {ld_year, ld_mon, ld_day, ld_hour, ld_min, ld_sec} = bin_time;

  assign leap     = is_leap(32'(year));
  assign max_date = days_in_month(month, leap);
  assign pm       = (hour >= 5'd12);
  assign hour12   = (hour == 5'd0) ? 4'd12 : (hour > 5'd12) ? 4'(hour - 5'd12) : 4'(hour);

  always_comb begin
    ld_max   = days_in_month(ld_mon, is_leap(32'(ld_year)));
    ld_valid = (32'(ld_year) >= YEAR_MIN) && (32'(ld_year) <= YEAR_MAX) &&
               (ld_mon >= 4'd1) && (ld_mon <= 4'd12) &&
               (ld_day >= 5'd1) && (ld_day <= ld_max) &&
               (ld_hour < 5'd24) && (ld_min < 6'd60) && (ld_sec < 6'd60);
  end

  watch_dow #(.YEAR_W(YEAR_W)) u_dow (
    .year  (ld_year),
    .month (ld_mon),
    .day   (ld_day),
    .week  (ld_week)
  );

  // Tick carry chain: each field rolls only when every lower field wraps.
  always_comb begin
    n_year = year;
    n_mon  = month;
    n_day  = day;
    n_hour = hour;
    n_min  = minute;
    n_sec  = second + 6'd1;
    n_week = week;
    n_mc   = 1'b0;
    n_hc   = 1'b0;
    n_dc   = 1'b0;
    if (second >= 6'd59) begin
      n_sec = '0;
      n_mc  = 1'b1;
      n_min = minute + 6'd1;
      if (minute >= 6'd59) begin
        n_min  = '0;
        n_hc   = 1'b1;
        n_hour = hour + 5'd1;
        if (hour >= 5'd23) begin
          n_hour = '0;
          n_dc   = 1'b1;
          n_week = (week >= 3'(SAT)) ? 3'(SUN) : week + 3'd1;
          n_day  = day + 5'd1;
          if (day >= max_date) begin
            n_day = 5'd1;
            n_mon = month + 4'd1;
            if (month >= 4'd12) begin
              n_mon  = 4'd1;
              n_year = (32'(year) >= YEAR_MAX) ? YEAR_W'(YEAR_MIN) : year + 1'b1;
            end
          end
        end
      end
    end
    n_alarm = alarm_en && (n_hour == alarm_hour) && (n_min == alarm_min) && (n_sec == 6'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year       <= YEAR_W'(RST_YEAR);
      month      <= 4'd12;
      day        <= 5'd31;
      hour       <= 5'd23;
      minute     <= 6'd59;
      second     <= 6'd50;
      week       <= 3'(RST_WEEK);
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
      set_ok     <= 1'b0;
      set_err    <= 1'b0;
      alarm_hit  <= 1'b0;
    end else begin
      min_carry  <= 1'b0;
      hour_carry <= 1'b0;
      day_carry  <= 1'b0;
      set_ok     <= 1'b0;
      set_err    <= 1'b0;
      alarm_hit  <= 1'b0;
      if (set_time) begin
        if (ld_valid) begin
          year   <= ld_year;
          month  <= ld_mon;
          day    <= ld_day;
          hour   <= ld_hour;
          minute <= ld_min;
          second <= ld_sec;
          week   <= ld_week;
          set_ok <= 1'b1;
        end else begin
          set_err <= 1'b1;
        end
      end else if (clk1sec) begin
        year       <= n_year;
        month      <= n_mon;
        day        <= n_day;
        hour       <= n_hour;
        minute     <= n_min;
        second     <= n_sec;
        week       <= n_week;
        min_carry  <= n_mc;
        hour_carry <= n_hc;
        day_carry  <= n_dc;
        alarm_hit  <= n_alarm;
      end
    end
  end

endmodule

// File: tb/tb_watch_calendar_gen2.sv
// Directed self-checking bench for watch_calendar_gen2 with hand-computed expectations.
module tb_watch_calendar_gen2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk1sec = 1'b0;
  logic        set_time = 1'b0;
  logic [37:0] bin_time = '0;
  logic        alarm_en = 1'b0;
  logic [4:0]  alarm_hour = '0;
  logic [5:0]  alarm_min = '0;
  logic [11:0] year;
  logic [3:0]  month;
  logic [4:0]  day, hour, max_date;
  logic [5:0]  minute, second;
  logic [2:0]  week;
  logic        leap, pm;
  logic [3:0]  hour12;
  logic        min_carry, hour_carry, day_carry, set_ok, set_err, alarm_hit;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  watch_calendar_gen2 #(
    .YEAR_W(12), .YEAR_MIN(1), .YEAR_MAX(4095), .RST_YEAR(2021), .RST_WEEK(5)
  ) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .set_time(set_time), .bin_time(bin_time),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .week(week), .max_date(max_date), .leap(leap), .hour12(hour12), .pm(pm),
    .min_carry(min_carry), .hour_carry(hour_carry), .day_carry(day_carry),
    .set_ok(set_ok), .set_err(set_err), .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [37:0] bt(input int unsigned y, mo, d, h, mi, s);
    return {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  function automatic logic [37:0] now();
    return {year, month, day, hour, minute, second};
  endfunction

  function automatic logic [5:0] pulses();
    return {min_carry, hour_carry, day_carry, set_ok, set_err, alarm_hit};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic [37:0] b);
    @(negedge clk);
    clk1sec  = t;
    set_time = s;
    bin_time = b;
    @(posedge clk);
    #1;
    clk1sec  = 1'b0;
    set_time = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", now(), bt(2021, 12, 31, 23, 59, 50));
    chk("rst_week", week, 3'd5);
    chk("rst_pulses", pulses(), 6'b0);
    chk("rst_maxdate", max_date, 5'd31);
    chk("rst_h12", {hour12, pm}, {4'd11, 1'b1});
    @(negedge clk);
    rst = 1'b1;

    // Ten ticks across the year boundary
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, '0);
    chk("tick9_time", now(), bt(2021, 12, 31, 23, 59, 59));
    chk("tick9_carry", {min_carry, hour_carry, day_carry}, 3'b000);
    cyc(1'b1, 1'b0, '0);
    chk("tick10_time", now(), bt(2022, 1, 1, 0, 0, 0));
    chk("tick10_week", week, 3'd6);
    chk("tick10_carry", {min_carry, hour_carry, day_carry}, 3'b111);
    cyc(1'b0, 1'b0, '0);
    chk("idle_pulses", pulses(), 6'b0);

    // Leap and non-leap February
    cyc(1'b0, 1'b1, bt(2024, 2, 28, 23, 59, 59));
    chk("ld2024_ok", {set_ok, set_err}, 2'b10);
    chk("ld2024_week", week, 3'd3);
    chk("ld2024_leap", {leap, max_date}, {1'b1, 5'd29});
    cyc(1'b1, 1'b0, '0);
    chk("tk2024_time", now(), bt(2024, 2, 29, 0, 0, 0));
    chk("tk2024_week", week, 3'd4);
    cyc(1'b0, 1'b1, bt(2023, 2, 28, 23, 59, 59));
    chk("ld2023_week", week, 3'd2);
    chk("ld2023_leap", {leap, max_date}, {1'b0, 5'd28});
    cyc(1'b1, 1'b0, '0);
    chk("tk2023_time", now(), bt(2023, 3, 1, 0, 0, 0));
    chk("tk2023_week", week, 3'd3);

    // Rejected loads leave state unchanged
    cyc(1'b0, 1'b1, bt(2023, 2, 29, 1, 2, 3));
    chk("bad_feb29_err", {set_ok, set_err}, 2'b01);
    chk("bad_feb29_time", now(), bt(2023, 3, 1, 0, 0, 0));
    cyc(1'b0, 1'b1, bt(2100, 2, 29, 1, 2, 3));
    chk("bad_2100_err", {set_ok, set_err}, 2'b01);
    chk("bad_2100_time", now(), bt(2023, 3, 1, 0, 0, 0));
    cyc(1'b0, 1'b1, bt(2023, 13, 1, 1, 2, 3));
    chk("bad_mon13_err", {set_ok, set_err}, 2'b01);
    cyc(1'b0, 1'b1, bt(2023, 1, 1, 24, 0, 0));
    chk("bad_hr24_err", {set_ok, set_err}, 2'b01);
    chk("bad_hr24_time", now(), bt(2023, 3, 1, 0, 0, 0));
    chk("bad_week", week, 3'd3);
    cyc(1'b0, 1'b1, bt(2000, 2, 29, 12, 0, 0));
    chk("ld2000_ok", {set_ok, set_err}, 2'b10);
    chk("ld2000_week", week, 3'd2);
    chk("h12_noon", {hour12, pm}, {4'd12, 1'b1});

    // Year wrap YEAR_MAX -> YEAR_MIN
    cyc(1'b0, 1'b1, bt(4095, 12, 31, 23, 59, 59));
    chk("ld4095_week", week, 3'd6);
    cyc(1'b1, 1'b0, '0);
    chk("wrap_time", now(), bt(1, 1, 1, 0, 0, 0));
    chk("wrap_week", week, 3'd0);
    chk("wrap_daycarry", day_carry, 1'b1);

    // Alarm
    alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 7, 29, 59));
    chk("alm_ld_nohit", alarm_hit, 1'b0);
    cyc(1'b1, 1'b0, '0);
    chk("alm_tick_time", now(), bt(2023, 6, 15, 7, 30, 0));
    chk("alm_tick_hit", alarm_hit, 1'b1);
    cyc(1'b1, 1'b0, '0);
    chk("alm_next_nohit", alarm_hit, 1'b0);
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 7, 30, 0));
    chk("alm_load_nohit", {set_ok, alarm_hit}, 2'b10);
    alarm_en = 1'b0;
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 7, 29, 59));
    cyc(1'b1, 1'b0, '0);
    chk("alm_dis_nohit", alarm_hit, 1'b0);
    cyc(1'b1, 1'b1, bt(2023, 6, 15, 8, 0, 0));
    chk("set_tick_time", now(), bt(2023, 6, 15, 8, 0, 0));
    chk("set_tick_pulses", pulses(), 6'b000100);

    // 12h view
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 0, 0, 0));
    chk("h12_midnight", {hour12, pm}, {4'd12, 1'b0});
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 13, 0, 0));
    chk("h12_13", {hour12, pm}, {4'd1, 1'b1});

    // Asynchronous reset between edges discards pending tick
    cyc(1'b0, 1'b1, bt(2023, 6, 15, 14, 0, 0));
    chk("pre_rst_ok", set_ok, 1'b1);
    #2;
    rst = 1'b0;
    clk1sec = 1'b1;
    #1;
    chk("async_rst_time", now(), bt(2021, 12, 31, 23, 59, 50));
    chk("async_rst_pulses", pulses(), 6'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_time", now(), bt(2021, 12, 31, 23, 59, 50));
    chk("rst_hold_week", week, 3'd5);
    clk1sec = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 1'b0, '0);
    chk("post_rst_tick", now(), bt(2021, 12, 31, 23, 59, 51));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
